// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_parser shared package: one-hot state codes, error codes,
// ASCII constants and the digit-decode result bundle.
package uart_cmd_pkg;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_KEY   = 5'b00010;
  localparam logic [4:0] S_EQ    = 5'b00100;
  localparam logic [4:0] S_NUM   = 5'b01000;
  localparam logic [4:0] S_DRAIN = 5'b10000;

  localparam logic [2:0] E_BAD_KEY   = 3'd1;
  localparam logic [2:0] E_NO_EQ     = 3'd2;
  localparam logic [2:0] E_BAD_DIGIT = 3'd3;
  localparam logic [2:0] E_OVERFLOW  = 3'd4;
  localparam logic [2:0] E_EMPTY     = 3'd5;
  localparam logic [2:0] E_SHORT     = 3'd6;

  localparam logic [7:0] ASC_EQ = 8'h3D;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_F  = 8'h46;
  localparam logic [7:0] ASC_Z  = 8'h5A;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_LF = 8'h66;
  localparam logic [7:0] ASC_UX = 8'h58;
  localparam logic [7:0] ASC_LX = 8'h78;

  typedef struct packed {
    logic       is_dec;
    logic       is_hex;
    logic [3:0] nib;
  } dig_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and command/error bus of uart_cmd_parser.
// master: framer/testbench side; slave: the parser.
interface uart_cmd_parser_if;
  logic        frm_start;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        frm_end;
  logic [7:0]  cmd_key;
  logic [31:0] cmd_value;
  logic        cmd_vld;
  logic        err_vld;
  logic [2:0]  err_code;
  logic        busy;

  modport master (
    output frm_start, in_data, in_vld, frm_end,
    input  cmd_key, cmd_value, cmd_vld,
    input  err_vld, err_code, busy
  );

  modport slave (
    input  frm_start, in_data, in_vld, frm_end,
    output cmd_key, cmd_value, cmd_vld,
    output err_vld, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_parser_decode.sv
// ascii_digit_decode: byte -> {is_dec, is_hex, nibble}.
// Ports: i_byte in 8, o_dig out dig_t.
module ascii_digit_decode
  import uart_cmd_pkg::*;
(
  input  logic [7:0] i_byte,
  output dig_t       o_dig
);

  always_comb begin
    o_dig = '0;
    unique case (1'b1)
      (i_byte >= ASC_0 && i_byte <= ASC_9): begin
        o_dig.is_dec = 1'b1;
        o_dig.is_hex = 1'b1;
        o_dig.nib    = i_byte[3:0];
      end
      (i_byte >= ASC_A && i_byte <= ASC_F),
      (i_byte >= ASC_LA && i_byte <= ASC_LF): begin
        o_dig.is_hex = 1'b1;
        o_dig.nib    = i_byte[3:0] + 4'd9;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes one "<KEY>=<value>" frame into key/value.
// Ports: sys_clk, sys_rst (sync, high), bus (uart_cmd_parser_if.slave).
// Option: UART_CMD_HEX_EN enables "0x"/"0X" hex values.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_DIGITS = 10
) (
  input logic              sys_clk,
  input logic              sys_rst,
  uart_cmd_parser_if.slave bus
);

  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  logic [4:0]  r_st;
  logic [31:0] r_acc;
  logic [3:0]  r_cnt;
  logic [7:0]  r_key;
  logic [7:0]  r_cmd_key;
  logic [31:0] r_cmd_val;
  logic        r_cmd_vld;
  logic        r_err_vld;
  logic [2:0]  r_err_code;

  logic [4:0]  w_st;
  logic [31:0] w_acc;
  logic [3:0]  w_cnt;
  logic [7:0]  w_key;
  logic        w_cmd;
  logic        w_err;
  logic [2:0]  w_code;
  logic [35:0] w_dec;
  dig_t        w_dig;

`ifdef UART_CMD_HEX_EN
  logic r_hex;
  logic w_hex;
`else
  logic w_unused_hex;
  assign w_unused_hex = w_dig.is_hex;
`endif

  ascii_digit_decode u_dec (
    .i_byte (bus.in_data),
    .o_dig  (w_dig)
  );

  // 36-bit so that acc*10+9 can never wrap
  assign w_dec = {4'd0, r_acc} * 36'd10
               + {32'd0, w_dig.nib};

  // start, then byte, then end -- each sees the previous step's result
  always_comb begin
    w_st   = r_st;
    w_acc  = r_acc;
    w_cnt  = r_cnt;
    w_key  = r_key;
    w_cmd  = 1'b0;
    w_err  = 1'b0;
    w_code = '0;
`ifdef UART_CMD_HEX_EN
    w_hex  = r_hex;
`endif
    if (bus.frm_start) begin
      w_st  = S_KEY;
      w_acc = '0;
      w_cnt = '0;
`ifdef UART_CMD_HEX_EN
      w_hex = 1'b0;
`endif
    end
    if (bus.in_vld) begin
      unique case (1'b1)
        (w_st == S_KEY): begin
          if (bus.in_data >= ASC_A &&
              bus.in_data <= ASC_Z) begin
            w_key = bus.in_data;
            w_st  = S_EQ;
          end else begin
            w_err  = 1'b1;
            w_code = E_BAD_KEY;
          end
        end
        (w_st == S_EQ): begin
          if (bus.in_data == ASC_EQ) begin
            w_st = S_NUM;
          end else begin
            w_err  = 1'b1;
            w_code = E_NO_EQ;
          end
        end
        (w_st == S_NUM): begin
`ifdef UART_CMD_HEX_EN
          if (w_hex) begin
            if (!w_dig.is_hex) begin
              w_err  = 1'b1;
              w_code = E_BAD_DIGIT;
            end else if (w_cnt >= 4'd8) begin
              w_err  = 1'b1;
              w_code = E_OVERFLOW;
            end else begin
              w_acc = {w_acc[27:0], w_dig.nib};
              w_cnt = w_cnt + 4'd1;
            end
          end else if ((bus.in_data == ASC_LX ||
                        bus.in_data == ASC_UX) &&
                       w_cnt == 4'd1 &&
                       w_acc == '0) begin
            // the lone leading '0' becomes the prefix
            w_hex = 1'b1;
            w_cnt = '0;
          end else
`endif
          if (!w_dig.is_dec) begin
            w_err  = 1'b1;
            w_code = E_BAD_DIGIT;
          end else if (w_cnt >= MAXD ||
                       w_dec[35:32] != 4'd0) begin
            w_err  = 1'b1;
            w_code = E_OVERFLOW;
          end else begin
            w_acc = w_dec[31:0];
            w_cnt = w_cnt + 4'd1;
          end
        end
        default: ;
      endcase
      if (w_err) w_st = S_DRAIN;
    end
    if (bus.frm_end && !bus.frm_start) begin
      unique case (1'b1)
        (w_st == S_NUM): begin
          if (w_cnt != 4'd0) begin
            w_cmd = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = E_EMPTY;
          end
          w_st = S_IDLE;
        end
        (w_st == S_KEY),
        (w_st == S_EQ): begin
          w_err  = 1'b1;
          w_code = E_SHORT;
          w_st   = S_IDLE;
        end
        (w_st == S_DRAIN): w_st = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_st       <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_key      <= '0;
      r_cmd_key  <= '0;
      r_cmd_val  <= '0;
      r_cmd_vld  <= 1'b0;
      r_err_vld  <= 1'b0;
      r_err_code <= '0;
`ifdef UART_CMD_HEX_EN
      r_hex      <= 1'b0;
`endif
    end else begin
      r_st      <= w_st;
      r_acc     <= w_acc;
      r_cnt     <= w_cnt;
      r_key     <= w_key;
      r_cmd_vld <= w_cmd;
      r_err_vld <= w_err;
      if (w_cmd) begin
        r_cmd_key <= w_key;
        r_cmd_val <= w_acc;
      end
      if (w_err) r_err_code <= w_code;
`ifdef UART_CMD_HEX_EN
      r_hex     <= w_hex;
`endif
    end
  end

  assign bus.cmd_key   = r_cmd_key;
  assign bus.cmd_value = r_cmd_val;
  assign bus.cmd_vld   = r_cmd_vld;
  assign bus.err_vld   = r_err_vld;
  assign bus.err_code  = r_err_code;
  assign bus.busy      = (r_st != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed frames plus random
// frames checked against a string-level reference parser.
module tb_uart_cmd_parser;

  localparam int MAXD = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.MAX_DIGITS(MAXD)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int          cyc = 0;
  int          n_cmd = 0;
  int          n_errs = 0;
  int          m_cyc = 0;
  logic [7:0]  m_key = '0;
  logic [31:0] m_val = '0;
  logic [2:0]  m_code = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.cmd_vld === 1'b1) begin
      n_cmd <= n_cmd + 1;
      m_key <= bus.cmd_key;
      m_val <= bus.cmd_value;
      m_cyc <= cyc;
    end
    if (bus.err_vld === 1'b1) begin
      n_errs <= n_errs + 1;
      m_code <= bus.err_code;
      m_cyc  <= cyc;
    end
  end

  logic [7:0] fr[$];
  int end_cyc;

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic set_fr(input string s);
    fr.delete();
    for (int i = 0; i < s.len(); i++)
      fr.push_back(s[i]);
  endtask

  task automatic pulse_start();
    @(posedge clk) #1;
    bus.frm_start = 1'b1;
    @(posedge clk) #1;
    bus.frm_start = 1'b0;
  endtask

  task automatic send_fr(input bit coinc, input bit do_end);
    for (int i = 0; i < fr.size(); i++) begin
      bus.in_vld  = 1'b1;
      bus.in_data = fr[i];
      bus.frm_end = do_end && coinc && (i == fr.size() - 1);
      @(posedge clk) #1;
      if (bus.frm_end) end_cyc = cyc;
      bus.in_vld  = 1'b0;
      bus.frm_end = 1'b0;
    end
    if (do_end && !coinc) begin
      bus.frm_end = 1'b1;
      @(posedge clk) #1;
      end_cyc = cyc;
      bus.frm_end = 1'b0;
    end
  endtask

  // reference: parse the frame string by the command grammar
  function automatic void model(output bit is_cmd,
                                output logic [2:0] code,
                                output logic [7:0] key,
                                output logic [31:0] val);
    longint acc = 0;
    int nd = 0;
    int d;
    bit hex = 1'b0;
    logic [7:0] c;
    is_cmd = 1'b0;
    code = 3'd0;
    key = 8'd0;
    val = 32'd0;
    if (fr.size() == 0) begin code = 3'd6; return; end
    if (fr[0] < "A" || fr[0] > "Z") begin
      code = 3'd1; return;
    end
    key = fr[0];
    if (fr.size() == 1) begin code = 3'd6; return; end
    if (fr[1] != "=") begin code = 3'd2; return; end
    for (int i = 2; i < fr.size(); i++) begin
      c = fr[i];
`ifdef UART_CMD_HEX_EN
      if (!hex && nd == 1 && acc == 0 &&
          (c == "x" || c == "X")) begin
        hex = 1'b1;
        nd = 0;
        continue;
      end
      if (hex) begin
        if (c >= "0" && c <= "9") d = int'(c) - 48;
        else if (c >= "a" && c <= "f") d = int'(c) - 87;
        else if (c >= "A" && c <= "F") d = int'(c) - 55;
        else begin code = 3'd3; return; end
        nd++;
        if (nd > 8) begin code = 3'd4; return; end
        acc = acc * 16 + d;
        continue;
      end
`endif
      if (c < "0" || c > "9") begin code = 3'd3; return; end
      d = int'(c) - 48;
      nd++;
      acc = acc * 10 + d;
      if (nd > MAXD || acc > 64'hFFFF_FFFF) begin
        code = 3'd4; return;
      end
    end
    if (hex || nd == 0) begin
      if (nd == 0) begin code = 3'd5; return; end
    end
    is_cmd = 1'b1;
    val = acc[31:0];
  endfunction

  task automatic check_frame(input string tag,
                             input int b_cmd,
                             input int b_err,
                             input bit e_cmd,
                             input logic [2:0] e_code,
                             input logic [7:0] e_key,
                             input logic [31:0] e_val);
    repeat (3) @(negedge clk);
    chk({tag, " cmd count"}, n_cmd - b_cmd, e_cmd ? 1 : 0);
    chk({tag, " err count"}, n_errs - b_err, e_cmd ? 0 : 1);
    if (e_cmd) begin
      chk({tag, " key"}, m_key, e_key);
      chk({tag, " value"}, m_val, e_val);
      chk({tag, " cmd latency"}, m_cyc, end_cyc);
    end else begin
      chk({tag, " err code"}, m_code, e_code);
      if (e_code == 3'd5 || e_code == 3'd6)
        chk({tag, " err latency"}, m_cyc, end_cyc);
    end
    chk({tag, " busy idle"}, bus.busy, 0);
  endtask

  task automatic run_frame(input string tag,
                           input bit coinc,
                           input bit e_cmd,
                           input logic [2:0] e_code,
                           input logic [7:0] e_key,
                           input logic [31:0] e_val);
    int b_cmd = n_cmd;
    int b_err = n_errs;
    pulse_start();
    send_fr(coinc, 1'b1);
    check_frame(tag, b_cmd, b_err, e_cmd, e_code,
                e_key, e_val);
  endtask

  task automatic gen_rand();
    int r = $urandom_range(0, 19);
    int nd;
    fr.delete();
    if (r == 7) return;
    if (r == 0) fr.push_back(8'(97 + $urandom_range(0, 25)));
    else fr.push_back(8'(65 + $urandom_range(0, 25)));
    if (r == 6) return;
    if (r == 1) fr.push_back(8'(48 + $urandom_range(0, 9)));
    else fr.push_back("=");
    if (r >= 2 && r <= 5) begin
      fr.push_back("4");
      nd = 9;
    end else begin
      nd = $urandom_range(0, 12);
    end
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 24) == 0)
        fr.push_back("x");
      else
        fr.push_back(8'(48 + $urandom_range(0, 9)));
    end
  endtask

  initial begin
    bit e_cmd;
    logic [2:0] e_code;
    logic [7:0] e_key;
    logic [31:0] e_val;
    bit coinc;
    int b_cmd;
    int b_err;

    bus.frm_start = 1'b0;
    bus.in_vld    = 1'b0;
    bus.in_data   = 8'h00;
    bus.frm_end   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset cmd_vld", bus.cmd_vld, 0);
    chk("reset err_vld", bus.err_vld, 0);
    chk("reset cmd_key", bus.cmd_key, 0);
    chk("reset cmd_value", bus.cmd_value, 0);
    chk("reset err_code", bus.err_code, 0);
    chk("reset busy", bus.busy, 0);

    set_fr("F=12345");
    run_frame("F=12345", 0, 1, 0, 8'h46, 12345);
    set_fr("A=4294967295");
    run_frame("max", 0, 1, 0, 8'h41, 32'hFFFF_FFFF);
    set_fr("A=429496729612");
    run_frame("ovf", 0, 0, 4, 0, 0);
    set_fr("A=0000000001");
    run_frame("10 digits", 0, 1, 0, 8'h41, 1);
    set_fr("A=00000000001");
    run_frame("11 digits", 0, 0, 4, 0, 0);
    set_fr("f=1");
    run_frame("lower key", 0, 0, 1, 0, 0);
    set_fr("F1");
    run_frame("no eq", 0, 0, 2, 0, 0);
    set_fr("F=1a");
    run_frame("bad digit", 0, 0, 3, 0, 0);
    set_fr("F=");
    run_frame("empty", 0, 0, 5, 0, 0);
    set_fr("F");
    run_frame("short", 0, 0, 6, 0, 0);
    set_fr("C=99");
    run_frame("coincident end", 1, 1, 0, 8'h43, 99);
    set_fr("D=5q");
    run_frame("coinc bad byte", 1, 0, 3, 0, 0);
`ifdef UART_CMD_HEX_EN
    set_fr("B=0x1aF");
    run_frame("hex", 0, 1, 0, 8'h42, 32'h1AF);
    set_fr("B=0x123456789");
    run_frame("hex ovf", 0, 0, 4, 0, 0);
    set_fr("B=0x");
    run_frame("hex empty", 0, 0, 5, 0, 0);
`else
    set_fr("B=0x1");
    run_frame("no hex", 0, 0, 3, 0, 0);
`endif

    b_cmd = n_cmd;
    b_err = n_errs;
    pulse_start();
    set_fr("F=12");
    send_fr(0, 0);
    pulse_start();
    set_fr("G=7");
    send_fr(0, 1);
    check_frame("restart", b_cmd, b_err, 1, 0, 8'h47, 7);

    b_cmd = n_cmd;
    b_err = n_errs;
    @(posedge clk) #1;
    bus.frm_start = 1'b1;
    bus.in_vld    = 1'b1;
    bus.in_data   = "H";
    @(posedge clk) #1;
    bus.frm_start = 1'b0;
    bus.in_vld    = 1'b0;
    set_fr("=5");
    send_fr(0, 1);
    check_frame("start+key", b_cmd, b_err, 1, 0, 8'h48, 5);

    b_cmd = n_cmd;
    b_err = n_errs;
    @(posedge clk) #1;
    bus.frm_end = 1'b1;
    @(posedge clk) #1;
    bus.frm_end = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray end strobes",
        (n_cmd - b_cmd) + (n_errs - b_err), 0);

    b_cmd = n_cmd;
    b_err = n_errs;
    pulse_start();
    set_fr("F=12");
    send_fr(0, 0);
    chk("busy mid frame", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset busy", bus.busy, 0);
    chk("mid reset cmd_key", bus.cmd_key, 0);
    chk("mid reset cmd_value", bus.cmd_value, 0);
    chk("mid reset err_code", bus.err_code, 0);
    @(posedge clk) #1;
    bus.frm_end = 1'b1;
    @(posedge clk) #1;
    bus.frm_end = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid reset strobes",
        (n_cmd - b_cmd) + (n_errs - b_err), 0);

    for (int k = 0; k < 40; k++) begin
      gen_rand();
      model(e_cmd, e_code, e_key, e_val);
      coinc = (fr.size() > 0) && ($urandom_range(0, 1) == 1);
      run_frame("rand", coinc, e_cmd, e_code, e_key, e_val);
    end

    $display("Result: errors=%0d of %0d checks",
             n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Consumes the payload byte stream of one received `&&...&&` UART frame and decodes a single ASCII command of the form `<KEY>=<value>` into a key byte and a 32-bit unsigned value. It sits directly downstream of the UART string framer: it takes payload bytes with frame-start and frame-end markers, and drives the FPGA control registers through a one-cycle command strobe. Malformed frames are rejected with an error code and never produce a command.

## Interface
- `MAX_DIGITS`, 10: maximum number of value digits accepted; range 1..10.
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: reset. Synchronous, active-high. One clock; reset is synchronous and active-high.
- `frm_start` in 1: one-cycle pulse marking the start of a frame; carries no data.
- `in_data` in 8: payload byte; valid only when `in_vld` is high.
- `in_vld` in 1: payload byte strobe.
- `frm_end` in 1: one-cycle pulse marking the closing `&&`; carries no data.
- `cmd_key` out 8: decoded key letter, `A`..`Z`.
- `cmd_value` out 32: decoded value.
- `cmd_vld` out 1: one-cycle strobe; `cmd_key` and `cmd_value` are valid in that cycle and hold their values until the next strobe.
- `err_vld` out 1: one-cycle error strobe.
- `err_code` out 3: error cause; held until the next error.
- `busy` out 1: high while a frame is being parsed.

## Operation
- States: IDLE, KEY, EQ, NUM, DRAIN.
- IDLE: `frm_start` → KEY; clear the accumulator and the digit counter. All other inputs are ignored, including a stray `frm_end`.
- KEY: a byte `A`..`Z` is latched as the key → EQ. Any other byte → error 1.
- EQ: byte `=` → NUM. Any other byte → error 2.
- NUM:
  - A byte `0`..`9` updates the accumulator: acc = acc*10 + (byte − `0`). Compute in 36 bits.
  - If the result exceeds 0xFFFF_FFFF, or the digit count would exceed `MAX_DIGITS` → error 4.
  - Any other byte → error 3.
- `frm_end` handling:
  - In NUM with ≥1 digit → emit the command → IDLE.
  - In NUM with 0 digits → error 5.
  - In KEY or EQ → error 6.
- On any error: pulse `err_vld`, load `err_code`, go to DRAIN. DRAIN discards bytes until `frm_end` → IDLE.
- `frm_start` in any non-IDLE state aborts the current frame silently and restarts at KEY. The accumulator is cleared and no error is reported.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - `cmd_key` = 0, `cmd_value` = 0, `cmd_vld` = 0.
  - `err_vld` = 0, `err_code` = 0, `busy` = 0.
  - State = IDLE.
- A reset asserted mid-frame discards the frame with no strobes.
- Throughput: one byte per cycle; `in_vld` may be high on consecutive cycles.
- `cmd_vld` and `err_vld` are registered. Each rises in the cycle after the triggering `frm_end` or bad byte.
- `in_vld` and `frm_end` in the same cycle: the byte is processed first, then the end is evaluated against the updated state and count. If that byte causes an error, only the error is reported.
- `frm_start` together with `in_vld` in the same cycle: the start applies first, and the byte is treated as the KEY byte.
- `frm_start` together with `frm_end`: the start wins and the end is ignored.
- At most one of `cmd_vld` / `err_vld` is asserted per frame.

## Configuration
- `UART_CMD_HEX_EN`
  - Defined: in NUM, a leading `0x` or `0X` switches to hex mode. Accepts `0`..`9`, `a`..`f`, `A`..`F`, computing acc = acc*16 + nibble, up to 8 hex digits. More than 8 digits → error 4. `0x` followed by no hex digit → error 5.
  - Undefined: `x` is an invalid digit (error 3), so `0x1` → error 3.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - State encodings (one-hot, 5 bits).
  - `err_code` constants: BAD_KEY=1, NO_EQ=2, BAD_DIGIT=3, OVERFLOW=4, EMPTY=5, SHORT=6.
  - ASCII constants for `=`, `0`, `9`, `A`, `Z`.
- One sub-module, `ascii_digit_decode`: combinational byte → {is_dec, is_hex, nibble[3:0]}.
  - Instantiated once.
  - Its hex-path output is used only when `UART_CMD_HEX_EN` is defined.

## Test plan
- Frame `F=12345` → `cmd_vld` one cycle after `frm_end`, with `cmd_key`=0x46 and `cmd_value`=12345. `err_vld` stays 0.
- `A=4294967295` → `cmd_value`=0xFFFF_FFFF.
- `A=4294967296` → `err_vld` with `err_code`=4 on the last digit. Later bytes are drained and no `cmd_vld` follows.
- Frame `f=1` → err 1. `F1` → err 2. `F=1a` → err 3. `F=` then end → err 5. `F` then end → err 6.
- `frm_start` again mid-frame after `F=12`, then `G=7` and end → a single `cmd_vld` with G/7 and no error.
- With `UART_CMD_HEX_EN` defined: `B=0x1aF` → value 0x1AF, and `B=0x123456789` → err 4. With it undefined: `B=0x1` → err 3.
- Back-to-back byte stream with `frm_end` coincident with the last digit `9` of `C=99` → value 99. A reset pulse mid-frame → all outputs 0 and no strobe.
